cache_control: RTL
==================

// Module: cache_control
// PURPOSE
// - Sequencing FSM for the 2-way, 8-set, 128-bit-line LC-3b cache datapath.
// - Sits between the CPU memory port (mem_read/mem_write/mem_resp) and physical memory (pmem_*).
// - Decodes hit/dirty/LRU status from the datapath and drives its mux selects and array write enables.
// - Runs hit, writeback and allocate sequences, and keeps saturating hit/miss/writeback counters.
// PARAMETERS
// - CNT_WIDTH  16  width of each performance counter; counters saturate at all-ones.
// PORTS
// - clk               in   1  clock; every state and counter update is on the rising edge.
// - rst_n             in   1  reset: asynchronous, active-low.
// - mem_read          in   1  CPU read request; held until mem_resp.
// - mem_write         in   1  CPU write request; held until mem_resp. Takes priority if both are high.
// - mem_resp          out  1  one-cycle completion pulse to the CPU.
// - pmem_read         out  1  line-fill request; held until pmem_resp.
// - pmem_write        out  1  line-writeback request; held until pmem_resp.
// - pmem_resp         in   1  physical-memory completion pulse.
// - ishit0_out, ishit1_out      in  1  way hit (tag match and valid), from the datapath.
// - dirtyarr0_out, dirtyarr1_out in 1  dirty bit of the indexed set, per way.
// - lru_out           in   1  victim way for the indexed set (0 = way0).
// - datainmux_sel     out  1  0: pmem_rdata feeds the data arrays; 1: merged CPU write block.
// - addressmux_sel    out  2  0: CPU address; 1: {tag0,index,0}; 2: {tag1,index,0}; 3: unused.
// - dataarr0_write, dataarr1_write, valid0_write, valid1_write, tag0_write, tag1_write,
//   dirtyarr0_write, dirtyarr1_write, lru_write   out  1 each  array write enables.
// - hit_count, miss_count, wb_count  out  CNT_WIDTH  performance counters.
// BEHAVIOUR
// - Outputs are Moore/Mealy combinational from the state and status inputs.
// - Defaults: every enable 0, datainmux_sel=0, addressmux_sel=0. This is also the value during reset.
// - Reset: state=S_IDLE and all counters=0, applied asynchronously. A reset mid-miss abandons the pmem cycle.
// - State S_IDLE (lookup), when a request is present:
//   - Hit way h: mem_resp=1 and lru_write=1 in the same cycle (lru datain = ~ishit1). hit_count increments.
//   - Write hit, also in that cycle: datainmux_sel=1, dataarr<h>_write=1, dirtyarr<h>_write=1.
//     Single-cycle hit latency.
//   - Miss with victim v = lru_out: miss_count increments.
//     - dirtyarr<v>_out=1 -> go to S_WB.
//     - Otherwise -> go to S_ALLOC.
//   - No request: stay in S_IDLE.
// - S_WB: pmem_write=1, addressmux_sel=1+v.
//   - On pmem_resp: wb_count increments, go to S_ALLOC.
// - S_ALLOC: pmem_read=1, addressmux_sel=0, datainmux_sel=0.
//   - On pmem_resp, same cycle: dataarr<v>_write, tag<v>_write, valid<v>_write, dirtyarr<v>_write=1.
//     The dirty bit takes mem_write: read miss clears it; write miss sets it.
//   - Then go to S_IDLE; the retried lookup hits, so a miss costs pmem latency + 1 lookup cycle.
// - v is re-read from lru_out each cycle; the LRU bit does not change during a miss, so v is stable.
// - CPU drops the request mid-miss: the pmem cycle in flight completes, its fill is written,
//   the FSM returns to S_IDLE, and no mem_resp is issued.
// - pmem_resp outside S_WB/S_ALLOC is ignored.
// - pmem_read and pmem_write are never high together.
// - mem_resp is never high outside S_IDLE.
// - Counters: +1 per event; held at 2^CNT_WIDTH-1 once reached; no wrap.
// STRUCTURE
// - lc3b_types package: add `typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} lc3b_cache_state;`
//   and the addressmux encodings ADDR_CPU=2'd0, ADDR_WAY0=2'd1, ADDR_WAY1=2'd2.
// - One sub-module, sat_counter #(width): a saturating counter with inc, async-active-low reset
//   and count. It is instantiated 3 times.
// - Everything else is the FSM: state register plus a combinational next-state/output always_comb.
// TESTING
// 1. Reset: rst_n=0 mid-S_ALLOC -> state S_IDLE immediately; all enables, pmem_* and counters are 0.
// 2. Read hit: mem_read=1, ishit1_out=1 -> same cycle mem_resp=1, lru_write=1, no dataarr write;
//    hit_count 0->1.
// 3. Write hit: mem_write=1, ishit0_out=1 -> dataarr0_write=1, dirtyarr0_write=1, datainmux_sel=1,
//    mem_resp=1, one cycle.
// 4. Clean read miss: lru_out=0, dirtyarr0_out=0 -> S_ALLOC with pmem_read=1, addressmux_sel=0.
//    pmem_resp after 5 cycles -> fill enables for way0. Next cycle hit gives mem_resp; miss_count=1, wb_count=0.
// 5. Dirty write miss: lru_out=1, dirtyarr1_out=1 -> pmem_write=1 with addressmux_sel=2 until pmem_resp.
//    Then pmem_read, fill way1 with dirty=1, then write hit; wb_count=1.
// 6. Saturation: CNT_WIDTH=2, 5 hits -> hit_count=3. Abandon: drop mem_read in S_ALLOC -> fill completes, no mem_resp.

Source files
------------

// File: rtl/cache_control_pkg.sv
// Shared types and constants for the LC-3b cache controller.
package lc3b_types;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WB    = 2'd1,
    S_ALLOC = 2'd2
  } lc3b_cache_state;

  localparam logic [1:0] ADDR_CPU  = 2'd0;
  localparam logic [1:0] ADDR_WAY0 = 2'd1;
  localparam logic [1:0] ADDR_WAY1 = 2'd2;

  // Writeback address select for the victim way: {tag<v>, index, 0}.
  function automatic logic [1:0] victim_addr_sel(input logic victim);
    return victim ? ADDR_WAY1 : ADDR_WAY0;
  endfunction

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter: counts increment pulses and sticks at all-ones.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [width-1:0] o_count
);

  logic [width-1:0] r_count;
  logic             w_full;

  assign w_full  = (r_count == {width{1'b1}});
  assign o_count = r_count;

  // Count register: clears on reset, increments on i_inc unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {width{1'b0}};
    end else if (i_inc && !w_full) begin
      r_count <= r_count + {{(width-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way, 8-set LC-3b cache: hit handling, victim
// writeback, line allocate, plus hit/miss/writeback performance counters.
module cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 ishit0_out,
  input  logic                 ishit1_out,
  input  logic                 dirtyarr0_out,
  input  logic                 dirtyarr1_out,
  input  logic                 lru_out,
  output logic                 datainmux_sel,
  output logic [1:0]           addressmux_sel,
  output logic                 dataarr0_write,
  output logic                 dataarr1_write,
  output logic                 valid0_write,
  output logic                 valid1_write,
  output logic                 tag0_write,
  output logic                 tag1_write,
  output logic                 dirtyarr0_write,
  output logic                 dirtyarr1_write,
  output logic                 lru_write,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  lc3b_cache_state r_state;
  lc3b_cache_state w_next_state;

  logic w_req;
  logic w_hit;
  logic w_victim;
  logic w_victim_dirty;
  logic w_hit_inc;
  logic w_miss_inc;
  logic w_wb_inc;

  assign w_req          = mem_read | mem_write;
  assign w_hit          = ishit0_out | ishit1_out;
  // LRU does not change during a miss, so the victim is stable across WB/ALLOC.
  assign w_victim       = lru_out;
  assign w_victim_dirty = w_victim ? dirtyarr1_out : dirtyarr0_out;

  // State register; reset abandons any pmem cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; everything held at defaults while in reset.
  always_comb begin
    w_next_state    = r_state;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    datainmux_sel   = 1'b0;
    addressmux_sel  = ADDR_CPU;
    dataarr0_write  = 1'b0;
    dataarr1_write  = 1'b0;
    valid0_write    = 1'b0;
    valid1_write    = 1'b0;
    tag0_write      = 1'b0;
    tag1_write      = 1'b0;
    dirtyarr0_write = 1'b0;
    dirtyarr1_write = 1'b0;
    lru_write       = 1'b0;
    w_hit_inc       = 1'b0;
    w_miss_inc      = 1'b0;
    w_wb_inc        = 1'b0;

    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_hit) begin
            mem_resp  = 1'b1;
            lru_write = 1'b1;
            w_hit_inc = 1'b1;
            if (mem_write) begin
              datainmux_sel = 1'b1;
              if (ishit0_out) begin
                dataarr0_write  = 1'b1;
                dirtyarr0_write = 1'b1;
              end else begin
                dataarr1_write  = 1'b1;
                dirtyarr1_write = 1'b1;
              end
            end else begin
              datainmux_sel = 1'b0;
            end
          end else if (w_req) begin
            w_miss_inc   = 1'b1;
            w_next_state = w_victim_dirty ? S_WB : S_ALLOC;
          end else begin
            w_next_state = S_IDLE;
          end
        end

        S_WB: begin
          pmem_write     = 1'b1;
          addressmux_sel = victim_addr_sel(w_victim);
          if (pmem_resp) begin
            w_wb_inc     = 1'b1;
            w_next_state = S_ALLOC;
          end else begin
            w_next_state = S_WB;
          end
        end

        S_ALLOC: begin
          pmem_read      = 1'b1;
          addressmux_sel = ADDR_CPU;
          datainmux_sel  = 1'b0;
          if (pmem_resp) begin
            // Dirty bit value comes from mem_write in the datapath.
            if (w_victim) begin
              dataarr1_write  = 1'b1;
              tag1_write      = 1'b1;
              valid1_write    = 1'b1;
              dirtyarr1_write = 1'b1;
            end else begin
              dataarr0_write  = 1'b1;
              tag0_write      = 1'b1;
              valid0_write    = 1'b1;
              dirtyarr0_write = 1'b1;
            end
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_ALLOC;
          end
        end

        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end else begin
      w_next_state = S_IDLE;
    end
  end

  sat_counter #(.width(CNT_WIDTH)) u_hit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_hit_inc),
    .o_count(hit_count)
  );

  sat_counter #(.width(CNT_WIDTH)) u_miss_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_miss_inc),
    .o_count(miss_count)
  );

  sat_counter #(.width(CNT_WIDTH)) u_wb_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_wb_inc),
    .o_count(wb_count)
  );

endmodule
